// File: rtl/frame_pp_pkg.sv
// ============================================================================
// Module   : frame_pp_pkg
// Purpose  : Shared FSM state types, bank bases and sizing helpers for the
//            ping-pong frame sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package frame_pp_pkg;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_REQ   = 2'd1,
      W_FDONE = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      R_WAIT_FIRST = 2'd0,
      R_RUN        = 2'd1,
      R_DRAIN      = 2'd2,
      R_FDONE      = 2'd3
   } rd_state_t;

   // BANK1_BASE holds for the default frame size; bank_base() serves other sizes.
   localparam int unsigned FRAME_PIXELS_DEF = 262144;
   localparam int unsigned BANK0_BASE       = 0;
   localparam int unsigned BANK1_BASE       = FRAME_PIXELS_DEF;

   function automatic int ost_width(input int rd_max);
      return $clog2(rd_max + 1);
   endfunction

   function automatic int unsigned bank_base(input logic bank, input int unsigned frame_pixels);
      return bank ? frame_pixels : BANK0_BASE;
   endfunction

endpackage

`default_nettype wire

// File: rtl/frame_pingpong_ctrl_if.sv
// ============================================================================
// Module   : frame_pingpong_ctrl_if
// Purpose  : Pixel-in, frame-store bus and display-out signal bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface frame_pingpong_ctrl_if #(
   parameter int ADDR_W = 19
);
   logic              in_valid;
   logic [31:0]       in_data;
   logic              in_ready;
   logic              write;
   logic [ADDR_W-1:0] write_addr;
   logic [31:0]       iData;
   logic              write_done;
   logic              read;
   logic [ADDR_W-1:0] read_addr;
   logic              read_done;
   logic              oValid;
   logic [31:0]       oData;
   logic              out_valid;
   logic [31:0]       out_data;
   logic              wr_bank;
   logic              proto_err;

   modport master (
      input  in_valid, in_data, write_done, read_done, oValid, oData,
      output in_ready, write, write_addr, iData, read, read_addr,
             out_valid, out_data, wr_bank, proto_err
   );

   modport slave (
      output in_valid, in_data, write_done, read_done, oValid, oData,
      input  in_ready, write, write_addr, iData, read, read_addr,
             out_valid, out_data, wr_bank, proto_err
   );
endinterface

`default_nettype wire

// File: rtl/frame_pp_addr_gen.sv
// ============================================================================
// Module   : frame_pp_addr_gen
// Purpose  : Per-frame word counter with bank base select and last-word flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_pp_addr_gen
   import frame_pp_pkg::*;
#(
   parameter int ADDR_W       = 19,
   parameter int FRAME_PIXELS = 262144
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              bank_i,
   input  wire logic              inc_i,
   input  wire logic              clr_i,
   output logic [ADDR_W-1:0]      addr_o,
   output logic                   last_o
);

   localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign last_o = (cnt_q == CNT_W'(FRAME_PIXELS - 1));
   assign addr_o = ADDR_W'(bank_base(bank_i, FRAME_PIXELS)) + ADDR_W'(cnt_q);

   // The counter parks on the last word; only a swap restarts it.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !last_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/frame_pingpong_ctrl.sv
// ============================================================================
// Module   : frame_pingpong_ctrl
// Purpose  : Ping-pong frame sequencer: writes the incoming frame to one bank
//            while reading the previous frame back from the other.
//            Optional build macro FRAME_PP_STATS_EN adds frame/stall counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_pingpong_ctrl
   import frame_pp_pkg::*;
#(
   parameter int ADDR_W       = 19,
   parameter int FRAME_PIXELS = 262144,
   parameter int RD_MAX       = 4
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   frame_pingpong_ctrl_if.master bus
`ifdef FRAME_PP_STATS_EN
   ,
   output logic [15:0]           frame_count,
   output logic [31:0]           stall_cycles
`endif
);

   localparam int OST_W = ost_width(RD_MAX);
   localparam int RTN_W = $clog2(FRAME_PIXELS + 1);

   if (2 * FRAME_PIXELS > (1 << ADDR_W)) begin : g_frame_size_err
      $error("frame_pingpong_ctrl: 2*FRAME_PIXELS exceeds the ADDR_W address space");
   end
   if (RD_MAX < 1 || RD_MAX > 15) begin : g_rd_max_err
      $error("frame_pingpong_ctrl: RD_MAX must be in 1..15");
   end

   wr_state_t         w_state_q, w_state_d;
   rd_state_t         r_state_q, r_state_d;
   logic              wr_bank_q;
   logic [ADDR_W-1:0] write_addr_q;
   logic [31:0]       idata_q;
   logic [OST_W-1:0]  ost_q, ost_d;
   logic [RTN_W-1:0]  rtn_q, rtn_d;
   logic              proto_err_q;
   logic              out_valid_q;
   logic [31:0]       out_data_q;

   logic              w_swap;
   logic              w_wr_accept;
   logic              w_wr_inc;
   logic              w_rd_inc;
   logic              w_rd_req;
   logic              w_rd_ack;
   logic              w_ret_ok;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [ADDR_W-1:0] w_rd_addr;
   logic              w_wr_last;
   logic              w_rd_last;

   frame_pp_addr_gen #(.ADDR_W(ADDR_W), .FRAME_PIXELS(FRAME_PIXELS)) u_wr_gen (
      .clk    (clk),
      .rst_n  (reset_n),
      .bank_i (wr_bank_q),
      .inc_i  (w_wr_inc),
      .clr_i  (w_swap),
      .addr_o (w_wr_addr),
      .last_o (w_wr_last)
   );

   frame_pp_addr_gen #(.ADDR_W(ADDR_W), .FRAME_PIXELS(FRAME_PIXELS)) u_rd_gen (
      .clk    (clk),
      .rst_n  (reset_n),
      .bank_i (~wr_bank_q),
      .inc_i  (w_rd_inc),
      .clr_i  (w_swap),
      .addr_o (w_rd_addr),
      .last_o (w_rd_last)
   );

   // The very first frame swaps straight out of R_WAIT_FIRST with no readback.
   assign w_swap      = (w_state_q == W_FDONE) &&
                        ((r_state_q == R_FDONE) || (r_state_q == R_WAIT_FIRST));
   assign w_wr_accept = (w_state_q == W_IDLE) && bus.in_valid;
   assign w_rd_req    = (r_state_q == R_RUN) && (ost_q < OST_W'(RD_MAX));
   assign w_rd_ack    = w_rd_req && bus.read_done;
   assign w_ret_ok    = bus.oValid && (ost_q != '0);

   always_comb begin
      w_state_d = w_state_q;
      w_wr_inc  = 1'b0;
      case (w_state_q)
         W_IDLE:  if (bus.in_valid) w_state_d = W_REQ;
         W_REQ: begin
            if (bus.write_done) begin
               if (w_wr_last) begin
                  w_state_d = W_FDONE;
               end else begin
                  w_state_d = W_IDLE;
                  w_wr_inc  = 1'b1;
               end
            end
         end
         W_FDONE: if (w_swap) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      w_rd_inc  = 1'b0;
      case (r_state_q)
         R_WAIT_FIRST: if (w_swap) r_state_d = R_RUN;
         R_RUN: begin
            if (w_rd_ack) begin
               if (w_rd_last) r_state_d = R_DRAIN;
               else           w_rd_inc  = 1'b1;
            end
         end
         R_DRAIN: if (rtn_q == RTN_W'(FRAME_PIXELS)) r_state_d = R_FDONE;
         R_FDONE: if (w_swap) r_state_d = R_RUN;
         default: r_state_d = R_WAIT_FIRST;
      endcase
   end

   always_comb begin
      ost_d = ost_q;
      case ({w_rd_ack, w_ret_ok})
         2'b10:   ost_d = ost_q + 1'b1;
         2'b01:   ost_d = ost_q - 1'b1;
         default: ost_d = ost_q;
      endcase
      rtn_d = rtn_q;
      if (w_swap) begin
         rtn_d = '0;
      end else if (w_ret_ok) begin
         rtn_d = rtn_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_state_q    <= W_IDLE;
         r_state_q    <= R_WAIT_FIRST;
         wr_bank_q    <= 1'b0;
         write_addr_q <= '0;
         idata_q      <= '0;
         ost_q        <= '0;
         rtn_q        <= '0;
         proto_err_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
      end else begin
         w_state_q   <= w_state_d;
         r_state_q   <= r_state_d;
         ost_q       <= ost_d;
         rtn_q       <= rtn_d;
         out_valid_q <= bus.oValid;
         out_data_q  <= bus.oData;
         if (w_swap) begin
            wr_bank_q <= ~wr_bank_q;
         end
         if (w_wr_accept) begin
            write_addr_q <= w_wr_addr;
            idata_q      <= bus.in_data;
         end
         if (bus.oValid && (ost_q == '0)) begin
            proto_err_q <= 1'b1;
         end
      end
   end

   assign bus.in_ready   = (w_state_q == W_IDLE);
   assign bus.write      = (w_state_q == W_REQ);
   assign bus.write_addr = write_addr_q;
   assign bus.iData      = idata_q;
   assign bus.read       = w_rd_req;
   assign bus.read_addr  = (r_state_q == R_RUN) ? w_rd_addr : '0;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.wr_bank    = wr_bank_q;
   assign bus.proto_err  = proto_err_q;

`ifdef FRAME_PP_STATS_EN
   logic [15:0] frame_count_q;
   logic [31:0] stall_q;

   // Both counters hold at all-ones rather than rolling over.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_count_q <= '0;
         stall_q       <= '0;
      end else begin
         if (w_swap && (frame_count_q != 16'hFFFF)) begin
            frame_count_q <= frame_count_q + 1'b1;
         end
         if (((w_state_q == W_FDONE) || (r_state_q == R_DRAIN)) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 1'b1;
         end
      end
   end

   assign frame_count  = frame_count_q;
   assign stall_cycles = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_pingpong_ctrl.sv
// ============================================================================
// Module   : tb_frame_pingpong_ctrl
// Purpose  : Directed bench for the ping-pong frame sequencer with a small
//            frame-store responder model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_frame_pingpong_ctrl;

   localparam int AW = 4;
   localparam int FP = 4;
   localparam int RM = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   frame_pingpong_ctrl_if #(.ADDR_W(AW)) bus ();

`ifdef FRAME_PP_STATS_EN
   logic [15:0] frame_count;
   logic [31:0] stall_cycles;
`endif

   frame_pingpong_ctrl #(.ADDR_W(AW), .FRAME_PIXELS(FP), .RD_MAX(RM)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef FRAME_PP_STATS_EN
      ,
      .frame_count  (frame_count),
      .stall_cycles (stall_cycles)
`endif
   );

   int          n_total = 0;
   int          n_bad   = 0;
   logic [31:0] mem [16];
   logic [31:0] pend [$];
   logic [31:0] rcv [$];
   logic [31:0] wr_log [$];
   logic [31:0] rd_log [$];
   int          rd_budget = 0;
   int          read_seen = 0;
   bit          wr_ack_en = 1'b1;
   bit          ret_en    = 1'b1;
   bit          force_ov  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.in_ready && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic send_px(input logic [31:0] d);
      wait_ready();
      chk("px_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_bank(input logic b, input string tag);
      int n = 0;
      while (bus.wr_bank !== b && n < 200) begin
         tick();
         n++;
      end
      chk(tag, bus.wr_bank, b);
   endtask

   // Frame-store model: acks on the falling edge; returns only requests
   // accepted on an earlier edge, in order.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.out_valid) rcv.push_back(bus.out_data);
         if (bus.read && !bus.wr_bank) read_seen++;
         if (bus.write && !bus.write_done && wr_ack_en) begin
            bus.write_done = 1'b1;
            mem[bus.write_addr] = bus.iData;
            wr_log.push_back(32'(bus.write_addr));
         end else begin
            bus.write_done = 1'b0;
         end
         if (force_ov) begin
            bus.oValid = 1'b1;
            bus.oData  = 32'hDEAD_BEEF;
            force_ov   = 1'b0;
         end else if (ret_en && pend.size() > 0) begin
            bus.oValid = 1'b1;
            bus.oData  = pend.pop_front();
         end else begin
            bus.oValid = 1'b0;
         end
         if (bus.read && rd_budget > 0) begin
            bus.read_done = 1'b1;
            rd_budget--;
            pend.push_back(mem[bus.read_addr]);
            rd_log.push_back(32'(bus.read_addr));
         end else begin
            bus.read_done = 1'b0;
         end
      end
   end

   initial begin
      int          k;
      bit          early_rdy;
      logic [31:0] s1;
      logic [31:0] first_addr;

      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.write_done = 1'b0;
      bus.read_done  = 1'b0;
      bus.oValid = 1'b0;
      bus.oData  = '0;
      for (int i = 0; i < 16; i++) mem[i] = '0;

      repeat (3) tick();
      chk("rst_in_ready",   bus.in_ready, 1);
      chk("rst_write",      bus.write, 0);
      chk("rst_read",       bus.read, 0);
      chk("rst_wr_bank",    bus.wr_bank, 0);
      chk("rst_proto_err",  bus.proto_err, 0);
      chk("rst_out_valid",  bus.out_valid, 0);
      chk("rst_write_addr", 32'(bus.write_addr), 0);
      chk("rst_read_addr",  32'(bus.read_addr), 0);
`ifdef FRAME_PP_STATS_EN
      chk("rst_frame_count", 32'(frame_count), 0);
      chk("rst_stall",       stall_cycles, 0);
`endif
      reset_n = 1'b1;
      tick();

      // Frame 1: writes to bank 0, no readback.
      read_seen = 0;
      for (int i = 0; i < 4; i++) send_px(32'hA0 + i);
      wait_bank(1'b1, "f1_swap");
      chk("f1_no_read", read_seen, 0);
      chk("f1_wr_count", wr_log.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("f1_waddr%0d", i), wr_log[i], i);
`ifdef FRAME_PP_STATS_EN
      chk("f1_frame_count", 32'(frame_count), 1);
`endif

      // Frame 2: writes to bank 1 while bank 0 reads back.
      rd_budget = 4;
      rcv.delete();
      for (int i = 0; i < 4; i++) send_px(32'hB0 + i);
      wait_bank(1'b0, "f2_swap");
      chk("f2_wr_count", wr_log.size(), 8);
      chk("f2_rd_count", rd_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("f2_waddr%0d", i), wr_log[4+i], 4 + i);
         chk($sformatf("f2_raddr%0d", i), rd_log[i], i);
      end
      chk("f2_rcv_count", rcv.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("f2_data%0d", i), rcv[i], 32'hA0 + i);
`ifdef FRAME_PP_STATS_EN
      chk("f2_frame_count", 32'(frame_count), 2);
`endif

      // Frame 3: read_done withheld, then capped by RD_MAX, then drained.
      ret_en = 1'b0;
      rcv.delete();
      for (int i = 0; i < 4; i++) send_px(32'hC0 + i);
      repeat (4) tick();
      chk("f3_hold_read",  bus.read, 1);
      chk("f3_hold_addr",  32'(bus.read_addr), 4);
      chk("f3_hold_acks",  rd_log.size(), 4);
      chk("f3_wr_stalled", bus.in_ready, 0);
      rd_budget = 4;
      repeat (6) tick();
      chk("f3_cap_acks",   rd_log.size(), 6);
      chk("f3_cap_addr4",  rd_log[4], 4);
      chk("f3_cap_addr5",  rd_log[5], 5);
      chk("f3_cap_read",   bus.read, 0);
      chk("f3_cap_budget", rd_budget, 2);
`ifdef FRAME_PP_STATS_EN
      s1 = stall_cycles;
      repeat (3) tick();
      chk("f3_stall_adv", stall_cycles, s1 + 3);
`endif
      ret_en = 1'b1;
      k = -1;
      early_rdy = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (k >= 0) k++;
         if (bus.wr_bank) break;
         if (bus.in_ready) early_rdy = 1'b1;
         if (k < 0 && rcv.size() == 4) k = 0;
      end
      chk("f3_swap",       bus.wr_bank, 1);
      chk("f3_swap_lat",   k, 1);
      chk("f3_rdy_held",   early_rdy, 0);
      chk("f3_rdy_after",  bus.in_ready, 1);
      chk("f3_rcv_count",  rcv.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("f3_data%0d", i), rcv[i], 32'hB0 + i);
      chk("f3_raddr6",     rd_log[6], 6);
      chk("f3_raddr7",     rd_log[7], 7);
      chk("f3_proto_ok",   bus.proto_err, 0);
`ifdef FRAME_PP_STATS_EN
      chk("f3_frame_count", 32'(frame_count), 3);
`endif

      // Stray oValid with nothing outstanding.
      tick();
      chk("pe_pre_read",   bus.read, 1);
      chk("pe_pre_addr",   32'(bus.read_addr), 0);
      force_ov = 1'b1;
      repeat (3) tick();
      chk("pe_set",        bus.proto_err, 1);
      chk("pe_read",       bus.read, 1);
      chk("pe_addr",       32'(bus.read_addr), 0);
      repeat (3) tick();
      chk("pe_sticky",     bus.proto_err, 1);

      // Reset while a write to address 6 is pending.
      send_px(32'hD0);
      send_px(32'hD1);
      wait_ready();
      wr_ack_en = 1'b0;
      send_px(32'hD2);
      tick();
      chk("mr_write",      bus.write, 1);
      chk("mr_waddr",      32'(bus.write_addr), 6);
      reset_n = 1'b0;
      #1;
      chk("mr_write_drop", bus.write, 0);
      chk("mr_wr_bank",    bus.wr_bank, 0);
      chk("mr_in_ready",   bus.in_ready, 1);
      chk("mr_proto_clr",  bus.proto_err, 0);
      chk("mr_read",       bus.read, 0);
`ifdef FRAME_PP_STATS_EN
      chk("mr_frame_count", 32'(frame_count), 0);
      chk("mr_stall",       stall_cycles, 0);
`endif
      tick();
      reset_n   = 1'b1;
      wr_ack_en = 1'b1;
      wr_log.delete();
      read_seen = 0;
      tick();
      send_px(32'hE0);
      for (int i = 0; i < 20 && wr_log.size() == 0; i++) tick();
      first_addr = (wr_log.size() > 0) ? wr_log[0] : 32'hFFFF_FFFF;
      chk("mr_first_addr", first_addr, 0);
      repeat (5) tick();
      chk("mr_no_read",    read_seen, 0);
      chk("mr_bank_hold",  bus.wr_bank, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
